// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends start, LSB-first data,
// optional parity and one stop bit, each bit lasting ClksPerBit clocks.
module uart_tx #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 868,
  parameter int ParityEn   = 0,
  parameter int ParityOdd  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  if (ClksPerBit < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: ClksPerBit must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t               r_state;
  logic [BaudW-1:0]     r_baud;
  logic [BitW-1:0]      r_bit;
  logic [DataWidth-1:0] r_shift;
  logic                 r_parity;

  logic                 w_baud_done;
  logic [DataWidth-1:0] w_shift_next;

  function automatic logic parity_of(input logic [DataWidth-1:0] d);
    return (^d) ^ (ParityOdd != 0);
  endfunction

  assign w_baud_done  = (r_baud == BaudLast);
  assign w_shift_next = r_shift >> 1;
  // The pop request is gated by reset so nothing is consumed during the reset cycle.
  assign fifo_rd_en_o = (r_state == S_IDLE) && !fifo_empty_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      // tx_o and busy_o are loaded with the value belonging to the next state.
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          tx_o   <= 1'b1;
          if (!fifo_empty_i) begin
            r_state <= S_FETCH;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_shift  <= fifo_rd_data_i;
          r_parity <= parity_of(fifo_rd_data_i);
          r_baud   <= '0;
          tx_o     <= 1'b0;
          r_state  <= S_START;
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            tx_o    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == BitLast) begin
              if (ParityEn != 0) begin
                tx_o    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                tx_o    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_next;
              tx_o    <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            tx_o    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          tx_o    <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised and directed bench for uart_tx: three instances (no parity, even, odd)
// checked every cycle against a frame-waveform model plus a bit-level line decoder.
module tb_uart_tx;
  localparam int C = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       empty_w [N];
  logic       rd_en_w [N];
  logic       tx_w    [N];
  logic       busy_w  [N];
  logic [7:0] rd_data [N];

  logic [7:0] mem [N][64];
  int         wr_ptr [N] = '{default: 0};
  int         rd_ptr [N] = '{default: 0};

  // Expected {tx, busy} for each upcoming cycle of a frame, and the current cycle's value.
  logic [1:0] exp_q    [N][$];
  logic       cur_tx   [N];
  logic       cur_busy [N];

  int checks = 0;
  int errors = 0;

  // Line decoder and bookkeeping, owned by the main process.
  logic        prev_tx  [N];
  int          hi_run   [N];
  int          hi_last  [N];
  int          dec_cnt  [N];
  bit          dec_act  [N];
  logic [10:0] dec_bits [N];
  logic [7:0]  rx_byte  [N];
  logic        rx_par   [N];
  int          rx_cnt   [N];
  int          busy_cnt [N];
  int          pop_cnt  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx #(
      .DataWidth (8),
      .ClksPerBit(C),
      .ParityEn  ((g != 0) ? 1 : 0),
      .ParityOdd ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .fifo_empty_i  (empty_w[g]),
      .fifo_rd_data_i(rd_data[g]),
      .fifo_rd_en_o  (rd_en_w[g]),
      .tx_o          (tx_w[g]),
      .busy_o        (busy_w[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N; i++) empty_w[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  function automatic void push_frame(input int i, input logic [7:0] d);
    logic p;
    p = (^d) ^ (i == 2);
    exp_q[i].push_back(2'b11);
    repeat (C) exp_q[i].push_back(2'b01);
    for (int k = 0; k < 8; k++) repeat (C) exp_q[i].push_back({d[k], 1'b1});
    if (i != 0) repeat (C) exp_q[i].push_back({p, 1'b1});
    repeat (C) exp_q[i].push_back(2'b11);
  endfunction

  // FIFO model and frame-waveform reference, advanced on each clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        exp_q[i].delete();
        cur_tx[i]   <= 1'b1;
        cur_busy[i] <= 1'b0;
      end else begin
        if (rd_en_w[i]) begin
          push_frame(i, mem[i][rd_ptr[i]]);
          rd_data[i] <= mem[i][rd_ptr[i]];
          rd_ptr[i]  <= rd_ptr[i] + 1;
        end
        if (exp_q[i].size() != 0) begin
          cur_tx[i]   <= exp_q[i][0][1];
          cur_busy[i] <= exp_q[i][0][0];
          exp_q[i].delete(0);
        end else begin
          cur_tx[i]   <= 1'b1;
          cur_busy[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic exp_rd;
    int   k;
    int   nb;
    for (int i = 0; i < N; i++) begin
      exp_rd = !rst && (exp_q[i].size() == 0) && !cur_busy[i] && !empty_w[i];
      check("tx", i, {31'd0, tx_w[i]}, {31'd0, cur_tx[i]});
      check("busy", i, {31'd0, busy_w[i]}, {31'd0, cur_busy[i]});
      check("rd_en", i, {31'd0, rd_en_w[i]}, {31'd0, exp_rd});
      if (busy_w[i] === 1'b1) busy_cnt[i]++;
      if (rd_en_w[i] === 1'b1) pop_cnt[i]++;
      nb = (i == 0) ? 10 : 11;
      if (rst) begin
        dec_act[i] = 1'b0;
        prev_tx[i] = 1'b1;
        hi_run[i]  = 0;
      end else begin
        if (!dec_act[i] && prev_tx[i] == 1'b1 && tx_w[i] == 1'b0) begin
          dec_act[i] = 1'b1;
          dec_cnt[i] = 1;
          hi_last[i] = hi_run[i];
        end else if (dec_act[i]) begin
          if (dec_cnt[i] >= 2 && ((dec_cnt[i] - 2) % C) == 0) begin
            k = (dec_cnt[i] - 2) / C;
            dec_bits[i][k] = tx_w[i];
            if (k == nb - 1) begin
              check("stop_bit", i, {31'd0, tx_w[i]}, 32'd1);
              rx_byte[i] = dec_bits[i][8:1];
              rx_par[i]  = dec_bits[i][9];
              rx_cnt[i]++;
              dec_act[i] = 1'b0;
            end
          end
          dec_cnt[i]++;
        end
        hi_run[i]  = tx_w[i] ? hi_run[i] + 1 : 0;
        prev_tx[i] = tx_w[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [7:0] d);
    for (int i = 0; i < N; i++) begin
      mem[i][wr_ptr[i]] = d;
      wr_ptr[i]++;
    end
  endtask

  task automatic wait_idle();
    int  n;
    bit  idle;
    n = 0;
    repeat (2) tick();
    idle = 1'b0;
    while (!idle && n < 1000) begin
      idle = 1'b1;
      for (int i = 0; i < N; i++) if (busy_w[i] !== 1'b0 || !empty_w[i]) idle = 1'b0;
      if (!idle) begin
        tick();
        n++;
      end
    end
    check("idle_timeout", 0, {31'd0, idle}, 32'd1);
  endtask

  int b0 [N];
  int p0;
  int r0;
  int n;
  logic [7:0] rnd;

  initial begin
    for (int i = 0; i < N; i++) begin
      busy_cnt[i] = 0; pop_cnt[i] = 0; rx_cnt[i] = 0; hi_run[i] = 0; hi_last[i] = 0;
      dec_act[i] = 1'b0; prev_tx[i] = 1'b1; dec_cnt[i] = 0; dec_bits[i] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("reset_tx", i, {31'd0, tx_w[i]}, 32'd1);
      check("reset_busy", i, {31'd0, busy_w[i]}, 32'd0);
    end

    // Empty FIFO: nothing happens for 100 cycles.
    repeat (100) tick();
    for (int i = 0; i < N; i++) begin
      check("empty_pops", i, pop_cnt[i], 32'd0);
      check("empty_tx", i, {31'd0, tx_w[i]}, 32'd1);
      check("empty_busy", i, {31'd0, busy_w[i]}, 32'd0);
    end

    // Single byte 0x55.
    for (int i = 0; i < N; i++) b0[i] = busy_cnt[i];
    push_all(8'h55);
    wait_idle();
    for (int i = 0; i < N; i++) begin
      check("b55_busy_len", i, busy_cnt[i] - b0[i], (i == 0) ? 32'd41 : 32'd45);
      check("b55_pops", i, pop_cnt[i], 32'd1);
      check("b55_byte", i, {24'd0, rx_byte[i]}, 32'h55);
    end
    check("b55_par_even", 1, {31'd0, rx_par[1]}, 32'd0);
    check("b55_par_odd", 2, {31'd0, rx_par[2]}, 32'd1);

    // Back-to-back 0xA5 then 0x3C.
    push_all(8'hA5);
    push_all(8'h3C);
    n = 0;
    while (rx_cnt[0] < 2 && n < 500) begin tick(); n++; end
    check("b2b_first", 0, {24'd0, rx_byte[0]}, 32'hA5);
    wait_idle();
    for (int i = 0; i < N; i++) begin
      check("b2b_second", i, {24'd0, rx_byte[i]}, 32'h3C);
      check("b2b_pops", i, pop_cnt[i], 32'd3);
    end
    check("b2b_high_run", 0, hi_last[0], 32'd10);

    // Parity on 0x07.
    for (int i = 0; i < N; i++) b0[i] = busy_cnt[i];
    push_all(8'h07);
    wait_idle();
    check("par_even_bit", 1, {31'd0, rx_par[1]}, 32'd1);
    check("par_odd_bit", 2, {31'd0, rx_par[2]}, 32'd0);
    check("par_frame_len", 1, busy_cnt[1] - b0[1], 32'd45);
    check("par_byte", 2, {24'd0, rx_byte[2]}, 32'h07);

    // Reset during data bit 3 of 0xF0.
    p0 = pop_cnt[0];
    r0 = rx_cnt[0];
    push_all(8'hF0);
    n = 0;
    while (pop_cnt[0] == p0 && n < 50) begin tick(); n++; end
    repeat (18) tick();
    check("mid_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    check("mid_bit3", 0, {31'd0, tx_w[0]}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("rst_mid_tx", i, {31'd0, tx_w[i]}, 32'd1);
      check("rst_mid_busy", i, {31'd0, busy_w[i]}, 32'd0);
    end
    repeat (10) tick();
    check("rst_no_pop", 0, pop_cnt[0], p0 + 1);
    check("rst_dropped", 0, rx_cnt[0], r0);
    push_all(8'h81);
    wait_idle();
    for (int i = 0; i < N; i++) check("after_rst_byte", i, {24'd0, rx_byte[i]}, 32'h81);
    check("after_rst_cnt", 0, rx_cnt[0], r0 + 1);

    // Random bytes, sometimes back-to-back, with idle gaps in between.
    for (int t = 0; t < 12; t++) begin
      rnd = 8'($urandom_range(0, 255));
      push_all(rnd);
      if ($urandom_range(0, 1) == 1) push_all(8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 60)) tick();
    end
    wait_idle();
    for (int i = 0; i < N; i++) check("rand_rx_vs_pops", i, rx_cnt[i], pop_cnt[i] - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
